// File: rtl/sdram_sr_cmd_tx.sv
// Serialises one SDRAM command word onto three 74595 chains (ser1/ser2/ser3) with a shared
// srclk, then pulses rclk. Optional SR_SKIP_DUP_EN suppresses re-sending an identical frame.
module sdram_sr_cmd_tx #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [12:0] cmd_addr,
    input  logic [1:0]  cmd_ba,
    input  logic [1:0]  cmd_dqm,
    input  logic        cmd_cke,
    input  logic        cmd_csb,
    input  logic        cmd_rasb,
    input  logic        cmd_casb,
    input  logic        cmd_web,
    output logic        ser1,
    output logic        ser2,
    output logic        ser3,
    output logic        srclk,
    output logic        rclk,
    output logic        busy,
    output logic        done
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO} state_t;

    state_t          state_reg;
    logic [DW-1:0]   div_reg;
    logic [2:0]      bit_reg;
    logic [7:0]      seq1_reg, seq2_reg, seq3_reg;
    logic            ser1_reg, ser2_reg, ser3_reg;
    logic            srclk_reg, rclk_reg, busy_reg, done_reg, skip_reg;
    logic [7:0]      seq1_next, seq2_next, seq3_next;
    logic            div_done;
    logic            accept;

    // Bit 0 of each sequence is shifted first and therefore ends up on QH.
    assign seq1_next = {cmd_addr[4], cmd_addr[12], cmd_addr[11], cmd_addr[9],
                        cmd_addr[8], cmd_addr[7], cmd_addr[6], cmd_addr[5]};
    assign seq2_next = {cmd_ba[0], 1'b0, cmd_addr[3], cmd_addr[2],
                        cmd_addr[1], cmd_addr[0], cmd_addr[10], cmd_ba[1]};
    assign seq3_next = {cmd_dqm[0], cmd_dqm[1], cmd_cke, cmd_csb,
                        cmd_rasb, cmd_casb, cmd_web, 1'b0};

    assign cmd_ready = (state_reg == IDLE) && rst_n && !skip_reg;
    assign accept    = cmd_valid && cmd_ready;
    assign div_done  = (div_reg == DIV_LAST);

`ifdef SR_SKIP_DUP_EN
    logic [23:0] last_reg;
    logic        last_valid_reg;
    logic        dup_hit;
    assign dup_hit = last_valid_reg && ({seq3_next, seq2_next, seq1_next} == last_reg);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            seq1_reg  <= '0;
            seq2_reg  <= '0;
            seq3_reg  <= '0;
            ser1_reg  <= 1'b0;
            ser2_reg  <= 1'b0;
            ser3_reg  <= 1'b0;
            srclk_reg <= 1'b0;
            rclk_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            skip_reg  <= 1'b0;
`ifdef SR_SKIP_DUP_EN
            last_reg       <= '0;
            last_valid_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            skip_reg <= 1'b0;
            if (state_reg != IDLE)
                div_reg <= div_done ? '0 : div_reg + DW'(1);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
`ifdef SR_SKIP_DUP_EN
                        if (dup_hit) begin
                            done_reg <= 1'b1;
                            skip_reg <= 1'b1;
                        end else
`endif
                        begin
                            state_reg <= SHIFT_LO;
                            seq1_reg  <= seq1_next;
                            seq2_reg  <= seq2_next;
                            seq3_reg  <= seq3_next;
                            ser1_reg  <= seq1_next[0];
                            ser2_reg  <= seq2_next[0];
                            ser3_reg  <= seq3_next[0];
                            div_reg   <= '0;
                            bit_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                SHIFT_LO: begin
                    if (div_done) begin
                        state_reg <= SHIFT_HI;
                        srclk_reg <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_done) begin
                        srclk_reg <= 1'b0;
                        if (bit_reg == 3'd7) begin
                            // ser* stay on bit 7 through the latch phase.
                            state_reg <= LATCH_HI;
                            rclk_reg  <= 1'b1;
                        end else begin
                            state_reg <= SHIFT_LO;
                            bit_reg   <= bit_reg + 3'd1;
                            ser1_reg  <= seq1_reg[bit_reg + 3'd1];
                            ser2_reg  <= seq2_reg[bit_reg + 3'd1];
                            ser3_reg  <= seq3_reg[bit_reg + 3'd1];
                        end
                    end
                end
                LATCH_HI: begin
                    if (div_done) begin
                        state_reg <= LATCH_LO;
                        rclk_reg  <= 1'b0;
                    end
                end
                LATCH_LO: begin
                    if (div_done) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`ifdef SR_SKIP_DUP_EN
                        last_reg       <= {seq3_reg, seq2_reg, seq1_reg};
                        last_valid_reg <= 1'b1;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ser1  = ser1_reg;
    assign ser2  = ser2_reg;
    assign ser3  = ser3_reg;
    assign srclk = srclk_reg;
    assign rclk  = rclk_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
endmodule

// File: tb/tb_sdram_sr_cmd_tx.sv
// Bench for sdram_sr_cmd_tx: cycle-by-cycle model from frame timing arithmetic plus a
// behavioural 74595 chain driven from the DUT pins.
module tb_sdram_sr_cmd_tx;
    localparam int D     = 3;
    localparam int FRAME = 18 * D;
`ifdef SR_SKIP_DUP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
    logic [12:0] cmd_addr = '0;
    logic [1:0]  cmd_ba = '0, cmd_dqm = '0;
    logic        cmd_cke = 1'b0, cmd_csb = 1'b0, cmd_rasb = 1'b0, cmd_casb = 1'b0, cmd_web = 1'b0;
    logic        cmd_ready, ser1, ser2, ser3, srclk, rclk, busy, done;

    always #5 clk = ~clk;

    sdram_sr_cmd_tx #(.CLK_DIV(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_ba(cmd_ba), .cmd_dqm(cmd_dqm), .cmd_cke(cmd_cke),
        .cmd_csb(cmd_csb), .cmd_rasb(cmd_rasb), .cmd_casb(cmd_casb), .cmd_web(cmd_web),
        .ser1(ser1), .ser2(ser2), .ser3(ser3), .srclk(srclk), .rclk(rclk),
        .busy(busy), .done(done)
    );

    // Input vector: addr 0-12, ba 13-14, dqm 15-16, cke 17, csb 18, rasb 19, casb 20, web 21.
    logic [21:0] in_vec;
    assign in_vec = {cmd_web, cmd_casb, cmd_rasb, cmd_csb, cmd_cke, cmd_dqm, cmd_ba, cmd_addr};

    // Send order per chip (first to last); -1 is a constant-zero slot.
    int map1 [8] = '{5, 6, 7, 8, 9, 11, 12, 4};
    int map2 [8] = '{14, 10, 0, 1, 2, 3, -1, 13};
    int map3 [8] = '{-1, 21, 20, 19, 18, 17, 16, 15};

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int src_of(input int c, input int n);
        return (c == 0) ? map1[n] : (c == 1) ? map2[n] : map3[n];
    endfunction

    function automatic logic seq_bit(input logic [21:0] v, input int c, input int n);
        int s;
        s = src_of(c, n);
        return (s < 0) ? 1'b0 : v[s];
    endfunction

    function automatic logic [2:0] ser_at(input logic [21:0] v, input int t);
        int n;
        n = t / (2 * D);
        if (n > 7) n = 7;
        return {seq_bit(v, 0, n), seq_bit(v, 1, n), seq_bit(v, 2, n)};
    endfunction

    function automatic logic [23:0] exp_q(input logic [21:0] v);
        logic [7:0] e [3];
        for (int c = 0; c < 3; c++)
            for (int n = 0; n < 8; n++)
                e[c][7-n] = seq_bit(v, c, n);
        return {e[0], e[1], e[2]};
    endfunction

    function automatic logic [21:0] mk(input logic [12:0] a, input logic [1:0] ba, input logic [1:0] dqm,
                                       input logic cke, input logic csb, input logic rasb,
                                       input logic casb, input logic web);
        return {web, casb, rasb, csb, cke, dqm, ba, a};
    endfunction

    // Model and monitor state
    int          m_t = -1;
    logic        m_done = 1'b0, m_skip = 1'b0, m_lv = 1'b0;
    logic [21:0] m_vec = '0, m_last = '0;
    logic [2:0]  m_ser = '0;
    int          cyc = 0, acc_count = 0, done_count = 0, acc_cyc = 0, prev_acc_cyc = 0;
    int          last_gap = 0, last_lat = 0, nsr = 0, nrc = 0;
    logic [7:0]  seq_s [3] = '{default: 8'h00};
    logic [7:0]  last_seq [3] = '{default: 8'h00};
    logic [7:0]  sh [3] = '{default: 8'h00};
    logic [7:0]  q [3] = '{default: 8'h00};
    logic        prev_srclk = 1'b0, prev_rclk = 1'b0;

    function automatic logic [12:0] q_addr();
        logic [12:0] a;
        a = '0;
        for (int c = 0; c < 3; c++)
            for (int n = 0; n < 8; n++)
                if (src_of(c, n) >= 0 && src_of(c, n) < 13) a[src_of(c, n)] = q[c][7-n];
        return a;
    endfunction

    always @(negedge clk) begin
        logic [7:0] exp_o, act_o;
        logic       e_sr, e_rc, e_busy, e_ready;
        logic [2:0] pins;
        cyc++;
        e_busy  = (m_t >= 0);
        e_sr    = e_busy && (m_t < 16 * D) && ((m_t % (2 * D)) >= D);
        e_rc    = e_busy && (m_t >= 16 * D) && (m_t < 17 * D);
        e_ready = !e_busy && rst_n && !m_skip;
        exp_o   = {e_ready, m_ser, e_sr, e_rc, e_busy, m_done};
        act_o   = {cmd_ready, ser1, ser2, ser3, srclk, rclk, busy, done};
        chk("cycle_outputs{ready,ser1,ser2,ser3,srclk,rclk,busy,done}", 32'(act_o), 32'(exp_o));

        // Off-chip 74595 chain driven by the DUT pins.
        pins = {ser1, ser2, ser3};
        if (srclk && !prev_srclk) begin
            nsr++;
            for (int c = 0; c < 3; c++) begin
                sh[c]    = {sh[c][6:0], pins[2-c]};
                seq_s[c] = {seq_s[c][6:0], pins[2-c]};
            end
        end
        if (rclk && !prev_rclk) begin
            nrc++;
            q = sh;
        end
        prev_srclk = srclk;
        prev_rclk  = rclk;

        if (m_done) begin
            done_count++;
            last_lat = cyc - acc_cyc;
            if (m_skip) begin
                chk("skip_srclk_rises", 32'(nsr), 32'd0);
                chk("skip_rclk_rises", 32'(nrc), 32'd0);
            end else begin
                chk("frame_srclk_rises", 32'(nsr), 32'd8);
                chk("frame_rclk_rises", 32'(nrc), 32'd1);
                chk("frame_q_image", 32'({q[0], q[1], q[2]}), 32'(exp_q(m_vec)));
                last_seq = seq_s;
            end
        end

        // Advance the model across the coming rising edge.
        if (!rst_n) begin
            m_t = -1; m_ser = '0; m_done = 1'b0; m_skip = 1'b0; m_lv = 1'b0;
        end else if (m_t >= 0) begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = -1; m_done = 1'b1; m_lv = 1'b1; m_last = m_vec;
            end else begin
                m_ser = ser_at(m_vec, m_t);
            end
        end else begin
            m_done = 1'b0;
            m_skip = 1'b0;
            if (cmd_valid && e_ready) begin
                acc_count++;
                prev_acc_cyc = acc_cyc;
                acc_cyc  = cyc + 1;
                last_gap = acc_cyc - prev_acc_cyc;
                nsr = 0; nrc = 0;
                seq_s = '{default: 8'h00};
                m_vec = in_vec;
                if (SKIP && m_lv && in_vec == m_last) begin
                    m_done = 1'b1; m_skip = 1'b1;
                end else begin
                    m_t = 0; m_ser = ser_at(in_vec, 0);
                end
            end
        end
    end

    task automatic set_fields(input logic [21:0] v);
        {cmd_web, cmd_casb, cmd_rasb, cmd_csb, cmd_cke, cmd_dqm, cmd_ba, cmd_addr} = v;
    endtask

    task automatic wait_accept();
        int start;
        start = acc_count;
        for (int k = 0; k < FRAME + 20; k++) begin
            @(posedge clk); #1;
            if (acc_count != start) return;
        end
        n_checks++; n_fail++;
        $display("FAIL accept_timeout @%0t: got no accept, expected one", $time);
    endtask

    task automatic send(input logic [21:0] v, input bit hold);
        set_fields(v);
        cmd_valid = 1'b1;
        wait_accept();
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        start = done_count;
        for (int k = 0; k < FRAME + 20; k++) begin
            @(posedge clk); #1;
            if (done_count != start) return;
        end
        n_checks++; n_fail++;
        $display("FAIL done_timeout @%0t: got no done, expected one", $time);
    endtask

    initial begin
        logic [21:0] pre, mrs, act, rda, v, prev;
        logic [7:0]  qs [3];
        pre = mk(13'h400, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        mrs = mk(13'h220, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        act = mk(13'h123, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        rda = mk(13'h400, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_srclk_rclk", 32'({srclk, rclk}), 32'd0);
        rst_n = 1'b1;

        // Precharge-all
        send(pre, 1'b0); wait_done();
        chk("pre_done_latency", 32'(last_lat), 32'(FRAME));
        chk("pre_ser1", 32'(last_seq[0]), 32'h00);
        chk("pre_ser2", 32'(last_seq[1]), 32'b01000000);
        chk("pre_ser3", 32'(last_seq[2]), 32'b00100100);

        // Mode-register write
        send(mrs, 1'b0); wait_done();
        chk("mrs_ser1", 32'(last_seq[0]), 32'b10001000);
        chk("mrs_ser3", 32'(last_seq[2]), 32'b00000100);
        chk("mrs_q_addr", 32'(q_addr()), 32'h220);

        // Back-to-back with valid held; fields change mid-frame
        send(act, 1'b1);
        set_fields(rda);
        wait_accept();
        chk("b2b_accept_gap", 32'(last_gap), 32'(FRAME + 1));
        cmd_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            set_fields(22'($urandom));
        end
        wait_done();
        chk("rda_q_addr", 32'(q_addr()), 32'h400);

        // Reset at cycle 7 of a frame
        qs = q;
        send(act, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_outputs", 32'({srclk, rclk, ser1, ser2, ser3, busy}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rclk_rises", 32'(nrc), 32'd0);
        chk("abort_q_kept", 32'({q[0], q[1], q[2]}), 32'({qs[0], qs[1], qs[2]}));
        send(act, 1'b0); wait_done();

        // Walking one
        for (int i = 0; i < 22; i++) begin
            send(22'(1) << i, 1'b0); wait_done();
            chk("walk_unused_q", 32'({q[1][1], q[2][7]}), 32'd0);
        end

        // Same command twice
        send(pre, 1'b0); wait_done();
        send(pre, 1'b0); wait_done();
        chk("dup_done_latency", 32'(last_lat), SKIP ? 32'd0 : 32'(FRAME));
        chk("dup_srclk_rises", 32'(nsr), SKIP ? 32'd0 : 32'd8);

        // Randomised traffic with repeats and mid-frame input noise
        prev = pre;
        for (int it = 0; it < 40; it++) begin
            v = ($urandom_range(0, 3) == 0) ? prev : 22'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(v, 1'b0);
            if (busy) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1 set_fields(22'($urandom));
            end
            wait_done();
            prev = v;
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
